// File: rtl/decimal_key_bcd_accumulator.sv
// Debounces ten one-hot decimal key lines and shifts each accepted digit into a
// multi-digit BCD entry register, calculator style, flagging multi-hot presses and overflow.
module decimal_key_bcd_accumulator #(
    parameter int NUM_DIGITS = 4,
    parameter int DEBOUNCE   = 4,
    parameter int CNT_W      = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [9:0]              d,
    input  logic                    clr,
    output logic [4*NUM_DIGITS-1:0] bcd,
    output logic [3:0]              digit_count,
    output logic [3:0]              key_code,
    output logic                    key_valid,
    output logic                    err,
    output logic                    ovf,
    output logic                    full
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam logic [3:0]       MAX_DIGITS = 4'(NUM_DIGITS);
    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE - 1);

    typedef enum logic [1:0] {IDLE, DEB_PRESS, HELD, DEB_REL} state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [9:0]         sample, sample_n;
    logic [BCD_W-1:0]   bcd_n;
    logic [3:0]         digit_count_n, key_code_n;
    logic               key_valid_n, err_n, ovf_n, full_n;
    logic               one_hot;
    logic [3:0]         code;

    always_comb begin
        one_hot = (sample != 10'd0) && ((sample & (sample - 10'd1)) == 10'd0);
        code    = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (sample[i]) code = 4'(i);
        end
    end

    // The accept event fires on the edge where the counter would reach DEBOUNCE.
    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        sample_n      = sample;
        bcd_n         = bcd;
        digit_count_n = digit_count;
        key_code_n    = key_code;
        key_valid_n   = 1'b0;
        err_n         = 1'b0;
        ovf_n         = 1'b0;

        case (state)
            IDLE: begin
                if (d != 10'd0) begin
                    sample_n = d;
                    cnt_n    = CNT_W'(1);
                    state_n  = DEB_PRESS;
                end
            end
            DEB_PRESS: begin
                if (d == 10'd0) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end else if (d != sample) begin
                    sample_n = d;
                    cnt_n    = CNT_W'(1);
                end else if (cnt == DEB_LAST) begin
                    cnt_n   = '0;
                    state_n = HELD;
                    if (one_hot) begin
                        key_code_n  = code;
                        key_valid_n = 1'b1;
                        if (digit_count == MAX_DIGITS) begin
                            ovf_n = 1'b1;
                        end else if (!(code == 4'd0 && digit_count == 4'd0)) begin
                            bcd_n         = bcd << 4;
                            bcd_n[3:0]    = code;
                            digit_count_n = digit_count + 4'd1;
                        end
                    end else begin
                        err_n = 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            HELD: begin
                if (d == 10'd0) begin
                    cnt_n   = CNT_W'(1);
                    state_n = DEB_REL;
                end
            end
            DEB_REL: begin
                if (d != 10'd0) begin
                    cnt_n   = '0;
                    state_n = HELD;
                end else if (cnt == DEB_LAST) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase

        // Clear beats a simultaneous accept: the digit is dropped but key_code still updates.
        if (clr) begin
            bcd_n         = '0;
            digit_count_n = 4'd0;
            ovf_n         = 1'b0;
        end

        full_n = (digit_count_n == MAX_DIGITS);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            sample      <= 10'd0;
            bcd         <= '0;
            digit_count <= 4'd0;
            key_code    <= 4'd0;
            key_valid   <= 1'b0;
            err         <= 1'b0;
            ovf         <= 1'b0;
            full        <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            sample      <= sample_n;
            bcd         <= bcd_n;
            digit_count <= digit_count_n;
            key_code    <= key_code_n;
            key_valid   <= key_valid_n;
            err         <= err_n;
            ovf         <= ovf_n;
            full        <= full_n;
        end
    end

endmodule

// File: tb/tb_decimal_key_bcd_accumulator.sv
// Directed self-checking bench for decimal_key_bcd_accumulator (4 digits, debounce of 4).
module tb_decimal_key_bcd_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  d;
    logic        clr;
    logic [15:0] bcd;
    logic [3:0]  digit_count;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        err;
    logic        ovf;
    logic        full;

    int tests_run    = 0;
    int tests_failed = 0;
    int kv_count, err_count, ovf_count, kv_at;

    decimal_key_bcd_accumulator #(
        .NUM_DIGITS(4),
        .DEBOUNCE  (4),
        .CNT_W     (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .d          (d),
        .clr        (clr),
        .bcd        (bcd),
        .digit_count(digit_count),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .err        (err),
        .ovf        (ovf),
        .full       (full)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts pulses seen over n cycles; kv_at is the 1-based tick of the first key_valid.
    task automatic observe(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            tick();
            if (key_valid) begin
                kv_count++;
                if (kv_at == 0) kv_at = base + i + 1;
            end
            if (err) err_count++;
            if (ovf) ovf_count++;
        end
    endtask

    task automatic clear_counts();
        kv_count  = 0;
        err_count = 0;
        ovf_count = 0;
        kv_at     = 0;
    endtask

    task automatic applyStimulus(input logic [9:0] v, input int hold, input int rel);
        clear_counts();
        d = v;
        observe(hold, 0);
        d = 10'd0;
        observe(rel, hold);
    endtask

    task automatic clear_entry();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        d     = 10'd0;
        clr   = 1'b0;
        tick();
        tick();
        checkOutput("reset_bcd", 32'(bcd), 32'h0);
        checkOutput("reset_count", 32'(digit_count), 32'd0);
        checkOutput("reset_code", 32'(key_code), 32'd0);
        checkOutput("reset_pulses", {29'd0, key_valid, err, ovf}, 32'd0);
        checkOutput("reset_full", 32'(full), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single key 3
        applyStimulus(10'h008, 6, 6);
        checkOutput("k3_kv_count", kv_count, 1);
        checkOutput("k3_kv_at", kv_at, 4);
        checkOutput("k3_code", 32'(key_code), 32'd3);
        checkOutput("k3_bcd", 32'(bcd), 32'h0003);
        checkOutput("k3_count", 32'(digit_count), 32'd1);
        checkOutput("k3_err", err_count, 0);

        clear_entry();
        checkOutput("clr_bcd", 32'(bcd), 32'h0);
        checkOutput("clr_count", 32'(digit_count), 32'd0);

        // Fill to four digits, then overflow on a fifth
        applyStimulus(10'h002, 6, 6);
        applyStimulus(10'h004, 6, 6);
        applyStimulus(10'h008, 6, 6);
        checkOutput("fill3_full", 32'(full), 32'd0);
        applyStimulus(10'h010, 6, 6);
        checkOutput("fill_bcd", 32'(bcd), 32'h1234);
        checkOutput("fill_full", 32'(full), 32'd1);
        checkOutput("fill_count", 32'(digit_count), 32'd4);
        applyStimulus(10'h020, 6, 6);
        checkOutput("ovf_count", ovf_count, 1);
        checkOutput("ovf_kv", kv_count, 1);
        checkOutput("ovf_code", 32'(key_code), 32'd5);
        checkOutput("ovf_bcd", 32'(bcd), 32'h1234);
        checkOutput("ovf_full", 32'(full), 32'd1);

        // Leading zeros are swallowed
        clear_entry();
        applyStimulus(10'h001, 6, 6);
        checkOutput("zero1_kv", kv_count, 1);
        checkOutput("zero1_count", 32'(digit_count), 32'd0);
        applyStimulus(10'h001, 6, 6);
        checkOutput("zero2_count", 32'(digit_count), 32'd0);
        checkOutput("zero2_bcd", 32'(bcd), 32'h0);
        applyStimulus(10'h080, 6, 6);
        checkOutput("k7_bcd", 32'(bcd), 32'h0007);
        checkOutput("k7_count", 32'(digit_count), 32'd1);

        // Multi-hot press and short glitch
        applyStimulus(10'h00C, 6, 6);
        checkOutput("multi_err", err_count, 1);
        checkOutput("multi_kv", kv_count, 0);
        checkOutput("multi_bcd", 32'(bcd), 32'h0007);
        checkOutput("multi_code", 32'(key_code), 32'd7);
        applyStimulus(10'h020, 2, 6);
        checkOutput("glitch_kv", kv_count, 0);
        checkOutput("glitch_err", err_count, 0);
        checkOutput("glitch_bcd", 32'(bcd), 32'h0007);

        // Clear on the same edge as an accepted key 9
        clear_entry();
        applyStimulus(10'h002, 6, 6);
        applyStimulus(10'h004, 6, 6);
        checkOutput("pre_clr_bcd", 32'(bcd), 32'h0012);
        d = 10'h200;
        tick();
        tick();
        tick();
        clr = 1'b1;
        tick();
        checkOutput("clracc_kv", 32'(key_valid), 32'd1);
        checkOutput("clracc_code", 32'(key_code), 32'd9);
        checkOutput("clracc_bcd", 32'(bcd), 32'h0);
        checkOutput("clracc_count", 32'(digit_count), 32'd0);
        checkOutput("clracc_ovf", 32'(ovf), 32'd0);
        clr = 1'b0;
        applyStimulus(10'h200, 2, 6);

        // Clear beats an overflowing key as well
        applyStimulus(10'h002, 6, 6);
        applyStimulus(10'h004, 6, 6);
        applyStimulus(10'h008, 6, 6);
        applyStimulus(10'h010, 6, 6);
        d = 10'h020;
        tick();
        tick();
        tick();
        clr = 1'b1;
        tick();
        checkOutput("clrfull_kv", 32'(key_valid), 32'd1);
        checkOutput("clrfull_ovf", 32'(ovf), 32'd0);
        checkOutput("clrfull_bcd", 32'(bcd), 32'h0);
        checkOutput("clrfull_full", 32'(full), 32'd0);
        clr = 1'b0;
        applyStimulus(10'h020, 2, 6);

        // Reset mid-debounce, key still held afterwards
        applyStimulus(10'h100, 6, 6);
        checkOutput("k8_bcd", 32'(bcd), 32'h0008);
        d = 10'h040;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_bcd", 32'(bcd), 32'h0);
        checkOutput("midrst_count", 32'(digit_count), 32'd0);
        checkOutput("midrst_code", 32'(key_code), 32'd0);
        tick();
        rst_n = 1'b1;
        clear_counts();
        observe(6, 0);
        d = 10'h000;
        observe(6, 6);
        checkOutput("rerun_kv_at", kv_at, 4);
        checkOutput("rerun_kv", kv_count, 1);
        checkOutput("rerun_code", 32'(key_code), 32'd6);
        checkOutput("rerun_bcd", 32'(bcd), 32'h0006);
        checkOutput("rerun_count", 32'(digit_count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
